alu_multicycle: RTL and testbench
=================================

ALU_MULTICYCLE -- requirements
Module: alu_multicycle

Interface
REQ-001 SHALL have port clk_i  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port rst_i  input  1  reset; synchronous, active-high.
REQ-003 SHALL have port start_i  input  1  request; sampled only when busy_o=0.
REQ-004 SHALL have port op_i  input  3  ALU control code: 000 ADD, 001 SUB, 010 MUL, 011 NOP, 100 AND, 101 XOR, 110 SLL, 111 SRA.
REQ-005 SHALL have port a_i  input  32  operand A (rs1 value).
REQ-006 SHALL have port b_i  input  32  operand B (rs2 value or immediate).
REQ-007 SHALL have port busy_o  output  1  high while a MUL is iterating.
REQ-008 SHALL have port done_o  output  1  one-cycle completion pulse.
REQ-009 SHALL have port result_o  output  32  last completed result; held until the next completion.

Function
REQ-010 SHALL implement FSM with states IDLE and MUL; IDLE is the reset state.
REQ-011 SHALL accept a request at an edge where state=IDLE and start_i=1, latching op_i, a_i and b_i at that edge.
REQ-012 SHALL, for ADD/SUB/AND/XOR/SLL/SRA/NOP, write result_o and pulse done_o=1 in the cycle right after acceptance; busy_o stays 0; latency 1.
REQ-013 SHALL allow single-cycle ops to be accepted back-to-back every cycle, with one done_o pulse per op.
REQ-014 SHALL compute ADD and SUB modulo 2^32, with no overflow or carry output.
REQ-015 SHALL compute SLL as a<<b[4:0] and SRA as an arithmetic (sign-filling) right shift of a by b[4:0]; b[31:5] are ignored.
REQ-016 SHALL complete NOP with result_o=0 and a done_o pulse.
REQ-017 SHALL run MUL as a radix-2 shift-add over 32 iterations, using a 5-bit counter cleared at acceptance, and SHALL produce the low 32 bits of a*b, which are identical for signed and unsigned operands.
REQ-018 SHALL drive busy_o=1 for exactly 32 cycles after MUL acceptance (edges E0..E31 complete); at edge E32 state returns to IDLE, busy_o=0, done_o=1 and result_o is updated; MUL latency is 32.
REQ-019 SHALL ignore start_i while busy_o=1; such a request is neither queued nor counted.
REQ-020 SHALL accept a new start_i in the same cycle that done_o=1, because state is IDLE then.
REQ-021 SHALL leave result_o unchanged during MUL iterations; intermediate products stay in internal registers.
REQ-022 SHALL ignore changes on op_i, a_i and b_i after acceptance for the rest of the operation.
REQ-023 SHALL drive done_o=0 in every cycle without a completion.

Reset
REQ-024 SHALL, when rst_i=1 at an edge, set state=IDLE, busy_o=0, done_o=0, result_o=0 and counter=0, overriding start_i.
REQ-025 SHALL abort an in-flight MUL on reset with no done_o pulse, and SHALL accept a new request at the first edge where rst_i=0.

Verification
REQ-026 SHALL cover: ADD a=0xFFFFFFFF, b=0x00000001 -> one cycle later done_o=1, result_o=0x00000000, busy_o never 1.
REQ-027 SHALL cover: SUB a=5, b=7, followed next cycle by XOR a=0xF0F0F0F0, b=0xFFFF0000 -> consecutive done_o pulses with result_o=0xFFFFFFFE then 0x0F0FF0F0.
REQ-028 SHALL cover: SRA a=0x80000000, b=0x00000024 -> result_o=0xF8000000; SLL a=1, b=31 -> result_o=0x80000000.
REQ-029 SHALL cover: MUL a=0xFFFFFFF9 (-7), b=3, with start_i held high throughout -> busy_o=1 for 32 cycles, one done_o pulse, result_o=0xFFFFFFEB; the held start then re-accepts in the done cycle.
REQ-030 SHALL cover: MUL a=0x12345678, b=0x10 with ADD requests driven during busy -> ADDs ignored, result_o=0x23456780 at 32-cycle latency.
REQ-031 SHALL cover: rst_i=1 at the 10th MUL cycle -> busy_o=0, done_o=0, result_o=0 next cycle, no late done_o; ADD 2+3 issued afterwards -> result_o=5.

Source files
------------

// File: rtl/alu_multicycle.sv
// alu_multicycle: 32-bit ALU. Every operation except MUL completes one cycle
// after acceptance. MUL is a 32-iteration radix-2 shift-add.
module alu_multicycle (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [2:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] result_o
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_MUL = 3'b010,
        OP_NOP = 3'b011,
        OP_AND = 3'b100,
        OP_XOR = 3'b101,
        OP_SLL = 3'b110,
        OP_SRA = 3'b111
    } op_t;

    state_t      r_state;
    logic [4:0]  r_cnt;
    logic [31:0] r_acc;
    logic [31:0] r_mcand;
    logic [31:0] r_mplier;
    logic [31:0] r_result;
    logic        r_busy;
    logic        r_done;

    logic [31:0] w_alu;
    logic [31:0] w_acc_next;

    // Single-cycle result, computed straight from the accepted inputs
    always_comb begin
        w_alu = '0;
        case (op_t'(op_i))
            OP_ADD:  w_alu = a_i + b_i;
            OP_SUB:  w_alu = a_i - b_i;
            OP_AND:  w_alu = a_i & b_i;
            OP_XOR:  w_alu = a_i ^ b_i;
            OP_SLL:  w_alu = a_i << b_i[4:0];
            OP_SRA:  w_alu = $unsigned($signed(a_i) >>> b_i[4:0]);
            default: w_alu = '0;
        endcase
    end

    // One shift-add step: add the shifted multiplicand when the multiplier LSB is set
    always_comb begin
        w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
    end

    // Control FSM with registered busy/done/result
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_result <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        if (op_t'(op_i) == OP_MUL) begin
                            r_state  <= S_MUL;
                            r_busy   <= 1'b1;
                            r_cnt    <= '0;
                            r_acc    <= '0;
                            r_mcand  <= a_i;
                            r_mplier <= b_i;
                        end else begin
                            r_result <= w_alu;
                            r_done   <= 1'b1;
                        end
                    end
                end
                S_MUL: begin
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + 5'd1;
                    if (r_cnt == 5'd31) begin
                        r_state  <= S_IDLE;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_result <= w_acc_next;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy_o   = r_busy;
    assign done_o   = r_done;
    assign result_o = r_result;

endmodule

// File: tb/tb_alu_multicycle.sv
// tb_alu_multicycle: table-driven single-cycle vectors plus directed MUL,
// busy-ignore and reset-abort sequences.
module tb_alu_multicycle;

    logic        clk_i;
    logic        rst_i;
    logic        start_i;
    logic [2:0]  op_i;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic        busy_o;
    logic        done_o;
    logic [31:0] result_o;

    int passed = 0;
    int total  = 0;

    localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, MUL = 3'b010, NOP = 3'b011,
                           AND = 3'b100, XOR = 3'b101, SLL = 3'b110, SRA = 3'b111;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[11];

    alu_multicycle dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .start_i  (start_i),
        .op_i     (op_i),
        .a_i      (a_i),
        .b_i      (b_i),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .result_o (result_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Advance past the next rising edge; outputs are then stable for sampling
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic drive(input logic s, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        start_i = s;
        op_i    = op;
        a_i     = a;
        b_i     = b;
    endtask

    initial begin
        logic [31:0] held;
        int          nbusy;
        int          nlate;
        bit          seen;

        vecs[0]  = '{ADD, 32'hFFFFFFFF, 32'h00000001, 32'h00000000};
        vecs[1]  = '{SUB, 32'h00000005, 32'h00000007, 32'hFFFFFFFE};
        vecs[2]  = '{XOR, 32'hF0F0F0F0, 32'hFFFF0000, 32'h0F0FF0F0};
        vecs[3]  = '{SRA, 32'h80000000, 32'h00000024, 32'hF8000000};
        vecs[4]  = '{SLL, 32'h00000001, 32'h0000001F, 32'h80000000};
        vecs[5]  = '{AND, 32'h12345678, 32'h0F0F0F0F, 32'h02040608};
        vecs[6]  = '{NOP, 32'hDEADBEEF, 32'h12345678, 32'h00000000};
        vecs[7]  = '{ADD, 32'h7FFFFFFF, 32'h00000001, 32'h80000000};
        vecs[8]  = '{SRA, 32'h7FFFFFF0, 32'hFFFFFFE4, 32'h07FFFFFF};
        vecs[9]  = '{SLL, 32'h0000000F, 32'h00000021, 32'h0000001E};
        vecs[10] = '{SUB, 32'h00000000, 32'h00000001, 32'hFFFFFFFF};

        rst_i = 1'b1;
        drive(1'b1, ADD, 32'h1, 32'h1);
        step();
        step();
        check("reset busy",   {31'b0, busy_o}, 32'd0);
        check("reset done",   {31'b0, done_o}, 32'd0);
        check("reset result", result_o,        32'd0);

        // Single-cycle ops, accepted back-to-back with start held high
        rst_i = 1'b0;
        for (int i = 0; i < 11; i++) begin
            drive(1'b1, vecs[i].op, vecs[i].a, vecs[i].b);
            step();
            check($sformatf("vec%0d done", i),   {31'b0, done_o}, 32'd1);
            check($sformatf("vec%0d busy", i),   {31'b0, busy_o}, 32'd0);
            check($sformatf("vec%0d result", i), result_o,        vecs[i].exp);
        end
        drive(1'b0, ADD, 32'h0, 32'h0);
        step();
        check("idle done low", {31'b0, done_o}, 32'd0);
        check("idle result held", result_o, 32'hFFFFFFFF);

        // MUL -7 * 3 with start held high throughout
        held = result_o;
        drive(1'b1, MUL, 32'hFFFFFFF9, 32'h00000003);
        step();
        nbusy = 0;
        for (int i = 0; i < 32; i++) begin
            if (busy_o) nbusy++;
            check("mul1 no early done", {31'b0, done_o}, 32'd0);
            check("mul1 result held", result_o, held);
            step();
        end
        check("mul1 busy cycles", nbusy, 32);
        check("mul1 done", {31'b0, done_o}, 32'd1);
        check("mul1 busy end", {31'b0, busy_o}, 32'd0);
        check("mul1 result", result_o, 32'hFFFFFFEB);
        step();
        check("mul1 reaccept busy", {31'b0, busy_o}, 32'd1);
        check("mul1 reaccept done", {31'b0, done_o}, 32'd0);
        drive(1'b0, ADD, 32'h0, 32'h0);
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            step();
            if (done_o) seen = 1;
        end
        check("mul1b completed", {31'b0, seen}, 32'd1);
        check("mul1b result", result_o, 32'hFFFFFFEB);

        // MUL with ADD requests driven while busy
        drive(1'b1, MUL, 32'h12345678, 32'h00000010);
        step();
        drive(1'b1, ADD, 32'h00000001, 32'h00000001);
        nbusy = 0;
        for (int i = 0; i < 32; i++) begin
            if (busy_o) nbusy++;
            check("mul2 add ignored", {31'b0, done_o}, 32'd0);
            check("mul2 result held", result_o, 32'hFFFFFFEB);
            step();
        end
        check("mul2 busy cycles", nbusy, 32);
        check("mul2 done", {31'b0, done_o}, 32'd1);
        check("mul2 result", result_o, 32'h23456780);
        step();
        check("add after mul done", {31'b0, done_o}, 32'd1);
        check("add after mul result", result_o, 32'h00000002);
        drive(1'b0, ADD, 32'h0, 32'h0);
        step();

        // Reset in the 10th MUL cycle aborts it
        drive(1'b1, MUL, 32'h00000003, 32'h00000005);
        step();
        drive(1'b0, ADD, 32'h0, 32'h0);
        for (int i = 0; i < 9; i++) step();
        check("mul3 still busy", {31'b0, busy_o}, 32'd1);
        rst_i = 1'b1;
        step();
        check("abort busy",   {31'b0, busy_o}, 32'd0);
        check("abort done",   {31'b0, done_o}, 32'd0);
        check("abort result", result_o,        32'd0);
        rst_i = 1'b0;
        drive(1'b1, ADD, 32'h00000002, 32'h00000003);
        step();
        check("post-reset add done", {31'b0, done_o}, 32'd1);
        check("post-reset add result", result_o, 32'h00000005);
        drive(1'b0, ADD, 32'h0, 32'h0);
        nlate = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (done_o || busy_o) nlate++;
        end
        check("no late done", nlate, 0);
        check("result kept", result_o, 32'h00000005);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
